// File: rtl/dec38_disp.sv
// Sequenced 3-to-8 decoder and display driver: buffers incoming codes in a
// 4-entry FIFO and shows each one as a one-hot LED pattern and 7-segment digit.
module dec38_disp #(
    parameter int unsigned HOLD_CYCLES = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] code,
    input  logic       code_valid,
    output logic       code_ready,
    output logic       overflow,
    output logic       busy,
    output logic [7:0] led,
    output logic       sign,
    output logic [6:0] hex
);

    typedef enum logic {
        IDLE,
        SHOW
    } state_e;

    localparam logic [23:0] HOLD_RELOAD = 24'(HOLD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  cur_q, cur_d;
    logic [23:0] timer_q, timer_d;
    logic        overflow_q, overflow_d;

    logic [2:0]  fifo_mem_q [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;

    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic        active;

    // Readiness ignores a same-cycle pop, so a full FIFO always rejects.
    assign code_ready = (count_q != 3'd4);
    assign fifo_empty = (count_q == 3'd0);
    assign push       = code_valid && code_ready;
    assign overflow_d = code_valid && !code_ready;

    // NOTE: combinational blocks assign every output a default first and use
    // blocking '='; that both avoids latches and models pure logic.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        timer_d = timer_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cur_d   = fifo_mem_q[rd_ptr_q];
                    timer_d = HOLD_RELOAD;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (en) begin
                    if (timer_q != 24'd0) begin
                        timer_d = timer_q - 24'd1;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        cur_d   = fifo_mem_q[rd_ptr_q];
                        timer_d = HOLD_RELOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_q      <= 3'd0;
            timer_q    <= 24'd0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            timer_q    <= timer_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: the storage array is not reset; count_q gates every read, so stale
    // contents are never observed and the array can map to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= code;
        end
    end

    function automatic logic [6:0] seg(input logic [2:0] c);
        case (c)
            3'd0:    seg = 7'b1000000;
            3'd1:    seg = 7'b1111001;
            3'd2:    seg = 7'b0100100;
            3'd3:    seg = 7'b0110000;
            3'd4:    seg = 7'b0011001;
            3'd5:    seg = 7'b0010010;
            3'd6:    seg = 7'b0000010;
            default: seg = 7'b1111000;
        endcase
    endfunction

    assign busy     = (state_q == SHOW);
    assign active   = busy && en;
    assign led      = active ? (8'b1 << cur_q) : 8'b0;
    assign sign     = active && (cur_q != 3'd0);
    assign hex      = active ? seg(cur_q) : 7'b1111111;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_dec38_disp.sv
// Directed bench for dec38_disp: reset, single codes, burst with overflow,
// pause via en, asynchronous reset mid-burst, and a HOLD_CYCLES=1 instance.
module tb_dec38_disp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [2:0] code = 3'd0;
    logic       code_valid = 1'b0;

    logic       code_ready, overflow, busy, sign;
    logic [7:0] led;
    logic [6:0] hex;

    logic       code_ready1, overflow1, busy1, sign1;
    logic [7:0] led1;
    logic [6:0] hex1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dec38_disp #(.HOLD_CYCLES(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .code(code), .code_valid(code_valid),
        .code_ready(code_ready), .overflow(overflow), .busy(busy),
        .led(led), .sign(sign), .hex(hex)
    );

    dec38_disp #(.HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .code(code), .code_valid(code_valid),
        .code_ready(code_ready1), .overflow(overflow1), .busy(busy1),
        .led(led1), .sign(sign1), .hex(hex1)
    );

    // Hand-written segment table for expected values.
    function automatic logic [6:0] exp_hex(input logic [2:0] c);
        case (c)
            3'd0:    exp_hex = 7'b1000000;
            3'd1:    exp_hex = 7'b1111001;
            3'd2:    exp_hex = 7'b0100100;
            3'd3:    exp_hex = 7'b0110000;
            3'd4:    exp_hex = 7'b0011001;
            3'd5:    exp_hex = 7'b0010010;
            3'd6:    exp_hex = 7'b0000010;
            default: exp_hex = 7'b1111000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %b want 00000000", led); end
        checks++;
        if (hex !== 7'b1111111) begin errors++; $display("FAIL reset_hex: got %b want 1111111", hex); end
        checks++;
        if (sign !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_sign_busy: got sign=%b busy=%b want 0 0", sign, busy);
        end
        checks++;
        if (code_ready !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("FAIL reset_ready_ovf: got ready=%b ovf=%b want 1 0", code_ready, overflow);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single(input logic [2:0] c, input logic [7:0] want_led,
                               input logic [6:0] want_hex, input logic want_sign);
        code = c;
        code_valid = 1'b1;
        tick();                         // edge 0: push
        code_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || led !== 8'h00) begin
            errors++; $display("FAIL single_edge0 code=%0d: got busy=%b led=%b want 0 00000000", c, busy, led);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (led !== want_led || hex !== want_hex || sign !== want_sign || busy !== 1'b1) begin
                errors++;
                $display("FAIL single_show code=%0d edge=%0d: got led=%b hex=%b sign=%b busy=%b want %b %b %b 1",
                         c, k, led, hex, sign, busy, want_led, want_hex, want_sign);
            end
        end
        tick();                         // edge 6
        checks++;
        if (led !== 8'h00 || hex !== 7'b1111111 || busy !== 1'b0) begin
            errors++; $display("FAIL single_end code=%0d: got led=%b hex=%b busy=%b want 00000000 1111111 0",
                               c, led, hex, busy);
        end
        tick();
    endtask

    task automatic test_burst_overflow();
        logic [2:0] burst [6] = '{3'd1, 3'd2, 3'd3, 3'd7, 3'd4, 3'd6};
        logic [2:0] shown [5] = '{3'd1, 3'd2, 3'd3, 3'd7, 3'd4};
        logic [7:0] want_led;
        logic       want_busy, want_ready, want_ovf;
        logic [2:0] sc;
        for (int e = 0; e <= 26; e++) begin
            if (e <= 5) begin
                code = burst[e];
                code_valid = 1'b1;
            end else begin
                code_valid = 1'b0;
            end
            tick();
            want_busy  = (e >= 1 && e <= 25);
            sc         = want_busy ? shown[(e - 1) / 5] : 3'd0;
            want_led   = want_busy ? (8'b1 << sc) : 8'h00;
            want_ready = !(e == 4 || e == 5);
            want_ovf   = (e == 5);
            checks++;
            if (led !== want_led || busy !== want_busy) begin
                errors++; $display("FAIL burst_display edge=%0d: got led=%b busy=%b want %b %b",
                                   e, led, busy, want_led, want_busy);
            end
            if (want_busy) begin
                checks++;
                if (hex !== exp_hex(sc)) begin
                    errors++; $display("FAIL burst_hex edge=%0d: got %b want %b", e, hex, exp_hex(sc));
                end
            end
            checks++;
            if (code_ready !== want_ready || overflow !== want_ovf) begin
                errors++; $display("FAIL burst_flow edge=%0d: got ready=%b ovf=%b want %b %b",
                                   e, code_ready, overflow, want_ready, want_ovf);
            end
        end
        tick();
    endtask

    task automatic test_pause();
        code = 3'd3;
        code_valid = 1'b1;
        tick();                         // edge 0
        code_valid = 1'b0;
        tick();                         // edge 1: first display cycle
        checks++;
        if (led !== 8'b00001000) begin errors++; $display("FAIL pause_first: got led=%b want 00001000", led); end
        tick();                         // edge 2
        en = 1'b0;
        for (int p = 0; p < 4; p++) begin
            #1;
            checks++;
            if (led !== 8'h00 || hex !== 7'b1111111 || busy !== 1'b1) begin
                errors++; $display("FAIL pause_blank cycle=%0d: got led=%b hex=%b busy=%b want 00000000 1111111 1",
                                   p, led, hex, busy);
            end
            tick();                     // edges 3..6 see en=0
        end
        en = 1'b1;
        #1;
        checks++;
        if (led !== 8'b00001000 || hex !== 7'b0110000) begin
            errors++; $display("FAIL pause_resume: got led=%b hex=%b want 00001000 0110000", led, hex);
        end
        for (int k = 7; k <= 9; k++) begin
            tick();
            checks++;
            if (led !== 8'b00001000 || busy !== 1'b1) begin
                errors++; $display("FAIL pause_remaining edge=%0d: got led=%b busy=%b want 00001000 1", k, led, busy);
            end
        end
        tick();                         // edge 10
        checks++;
        if (led !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL pause_end: got led=%b busy=%b want 00000000 0", led, busy);
        end
        tick();
    endtask

    task automatic test_async_reset();
        logic [2:0] seq [4] = '{3'd2, 3'd4, 3'd6, 3'd1};
        for (int i = 0; i < 4; i++) begin
            code = seq[i];
            code_valid = 1'b1;
            tick();
        end
        code_valid = 1'b0;
        checks++;
        if (led !== 8'b00000100 || busy !== 1'b1) begin
            errors++; $display("FAIL areset_pre: got led=%b busy=%b want 00000100 1", led, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 8'h00 || hex !== 7'b1111111 || busy !== 1'b0 || code_ready !== 1'b1) begin
            errors++; $display("FAIL areset_immediate: got led=%b hex=%b busy=%b ready=%b want 00000000 1111111 0 1",
                               led, hex, busy, code_ready);
        end
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (led !== 8'h00 || busy !== 1'b0) begin
                errors++; $display("FAIL areset_after cycle=%0d: got led=%b busy=%b want 00000000 0", k, led, busy);
            end
        end
    endtask

    task automatic test_hold1();
        code = 3'd3;
        code_valid = 1'b1;
        tick();                         // edge 0: push 3
        code = 3'd5;
        tick();                         // edge 1: pop 3, push 5
        code_valid = 1'b0;
        checks++;
        if (led1 !== 8'b00001000 || busy1 !== 1'b1) begin
            errors++; $display("FAIL hold1_first: got led=%b busy=%b want 00001000 1", led1, busy1);
        end
        tick();                         // edge 2: next code without gap
        checks++;
        if (led1 !== 8'b00100000 || hex1 !== 7'b0010010 || sign1 !== 1'b1) begin
            errors++; $display("FAIL hold1_second: got led=%b hex=%b sign=%b want 00100000 0010010 1",
                               led1, hex1, sign1);
        end
        tick();                         // edge 3: drained
        checks++;
        if (led1 !== 8'h00 || busy1 !== 1'b0) begin
            errors++; $display("FAIL hold1_end: got led=%b busy=%b want 00000000 0", led1, busy1);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single(3'd5, 8'b00100000, 7'b0010010, 1'b1);
        test_single(3'd0, 8'b00000001, 7'b1000000, 1'b0);
        test_burst_overflow();
        test_pause();
        test_async_reset();
        test_hold1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
